// File: rtl/bcd_entry_pkg.sv
// ---------------------------------------------------------------------------
// bcd_entry_pkg
// Shared definitions for the BCD operand-entry front end.
//   STATE_W        : width of the entry FSM state code
//   entry_state_e  : FSM state encoding (S_A, S_B, S_CIN, S_DONE)
//   BCD_MAX        : largest digit accepted as a BCD operand
//   is_bcd()       : true when a 4-bit digit is a legal BCD value
// ---------------------------------------------------------------------------
package bcd_entry_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CIN  = 2'd2,
    S_DONE = 2'd3
  } entry_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises one raw active-low pushbutton, debounces it and emits a
// single-cycle pulse when the debounced level falls (button pressed).
// Releasing the button produces no pulse.
//   clk          : system clock
//   reset        : synchronous, active-high reset
//   key_n        : raw asynchronous active-low button
//   press_pulse  : one-cycle pulse, high during the cycle whose closing edge
//                  also flips the debounced level from 1 to 0
// Parameters:
//   DEBOUNCE_CYCLES : consecutive differing cycles needed to accept a change
//   CNT_W           : counter width, 2^CNT_W > DEBOUNCE_CYCLES
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q,   deb_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             pulse_s;

  // Next-state for synchroniser, stability counter and debounced level.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    pulse_s = 1'b0;
    if (sync2_q == deb_q) begin
      // Input agrees with the accepted level: any partial run is a bounce.
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      deb_d   = ~deb_q;
      cnt_d   = CNT_ZERO;
      // Only the 1->0 (press) direction is an event.
      pulse_s = deb_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Register update; reset releases the key and abandons any debounce run.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= CNT_ZERO;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_pulse = pulse_s;

endmodule

// File: rtl/bcd_operand_entry.sv
// ---------------------------------------------------------------------------
// bcd_operand_entry
// Operand-entry front end for the BCD adder / seven-segment path. Each
// debounced press of ENTER captures, in turn, operand A, operand B and the
// carry-in; a fourth press drops the valid flag and restarts at A. CLEAR
// returns everything to the start state and wins over a simultaneous ENTER.
//   CLOCK_50        : system clock
//   reset           : synchronous, active-high reset
//   digit_in[3:0]   : digit from SW[3:0]
//   cin_in          : carry-in from SW[8]
//   key_enter_n     : raw active-low ENTER button
//   key_clear_n     : raw active-low CLEAR button
//   a_out[3:0]      : latched operand A
//   b_out[3:0]      : latched operand B
//   cin_out         : latched carry-in
//   operands_valid  : A, B and carry-in all captured
//   digit_err       : sticky flag for a rejected non-BCD digit
//   entry_state[1:0]: current FSM state code
// Build option:
//   BCD_ENTRY_HEX_EN : when defined, digits 10-15 are accepted for A and B
//                      (hex-adder variant) and digit_err never sets.
// ---------------------------------------------------------------------------
module bcd_operand_entry
  import bcd_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [3:0]         digit_in,
  input  logic               cin_in,
  input  logic               key_enter_n,
  input  logic               key_clear_n,
  output logic [3:0]         a_out,
  output logic [3:0]         b_out,
  output logic               cin_out,
  output logic               operands_valid,
  output logic               digit_err,
  output logic [STATE_W-1:0] entry_state
);

  logic enter_pulse;
  logic clear_pulse;
  logic digit_ok;

  entry_state_e state_q, state_d;
  logic [3:0]   a_q,     a_d;
  logic [3:0]   b_q,     b_d;
  logic         cin_q,   cin_d;
  logic         valid_q, valid_d;
  logic         err_q,   err_d;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_enter_key (
    .clk         (CLOCK_50),
    .reset       (reset),
    .key_n       (key_enter_n),
    .press_pulse (enter_pulse)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_clear_key (
    .clk         (CLOCK_50),
    .reset       (reset),
    .key_n       (key_clear_n),
    .press_pulse (clear_pulse)
  );

`ifdef BCD_ENTRY_HEX_EN
  assign digit_ok = 1'b1;
`else
  assign digit_ok = is_bcd(digit_in);
`endif

  // Entry FSM next-state and output-register next values.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (clear_pulse) begin
      // Clear takes priority; a same-cycle enter is dropped.
      state_d = S_A;
      a_d     = 4'd0;
      b_d     = 4'd0;
      cin_d   = 1'b0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (enter_pulse) begin
      case (state_q)
        S_A: begin
          if (digit_ok) begin
            a_d     = digit_in;
            err_d   = 1'b0;
            state_d = S_B;
          end else begin
            err_d   = 1'b1;
          end
        end
        S_B: begin
          if (digit_ok) begin
            b_d     = digit_in;
            err_d   = 1'b0;
            state_d = S_CIN;
          end else begin
            err_d   = 1'b1;
          end
        end
        S_CIN: begin
          cin_d   = cin_in;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          // Operands stay visible until the next capture overwrites them.
          valid_d = 1'b0;
          state_d = S_A;
        end
        default: begin
          state_d = S_A;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM state and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_A;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign a_out          = a_q;
  assign b_out          = b_q;
  assign cin_out        = cin_q;
  assign operands_valid = valid_q;
  assign digit_err      = err_q;
  assign entry_state    = state_q;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// ---------------------------------------------------------------------------
// tb_bcd_operand_entry
// Directed bench for bcd_operand_entry with DEBOUNCE_CYCLES=4. A behavioural
// model (raw samples seen two edges late, a level accepted after DB
// consecutive differing samples, then the operand-entry rules) is compared
// with the DUT outputs on every falling edge; literal checks at key points
// pin the model. Honours BCD_ENTRY_HEX_EN when defined.
// ---------------------------------------------------------------------------
module tb_bcd_operand_entry;

  localparam int DB = 4;
  localparam int CW = 3;
`ifdef BCD_ENTRY_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] digit_in;
  logic       cin_in;
  logic       key_enter_n;
  logic       key_clear_n;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       cin_out;
  logic       operands_valid;
  logic       digit_err;
  logic [1:0] entry_state;

  int checks   = 0;
  int failures = 0;

  bcd_operand_entry #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (CW)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .digit_in       (digit_in),
    .cin_in         (cin_in),
    .key_enter_n    (key_enter_n),
    .key_clear_n    (key_clear_n),
    .a_out          (a_out),
    .b_out          (b_out),
    .cin_out        (cin_out),
    .operands_valid (operands_valid),
    .digit_err      (digit_err),
    .entry_state    (entry_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_dly [2][2];   // raw samples, visible two edges later
  int         m_run [2];      // consecutive samples differing from accepted level
  logic       m_lvl [2];      // accepted (debounced) level
  logic [3:0] m_a, m_b;
  logic       m_cin, m_valid, m_err;
  int         m_st;
  bit         m_live = 1'b0;

  initial begin
    logic       rst_s;
    logic       raw [2];
    logic       ev  [2];
    logic [3:0] dig;
    logic       cin_s;
    logic       seen;
    forever begin
      @(posedge clk);
      rst_s  = reset;
      raw[0] = key_enter_n;
      raw[1] = key_clear_n;
      dig    = digit_in;
      cin_s  = cin_in;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ev[i] = 1'b0;
        if (rst_s) begin
          m_dly[i][0] = 1'b1;
          m_dly[i][1] = 1'b1;
          m_run[i]    = 0;
          m_lvl[i]    = 1'b1;
        end else begin
          seen        = m_dly[i][1];
          m_dly[i][1] = m_dly[i][0];
          m_dly[i][0] = raw[i];
          if (seen != m_lvl[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DB) begin
              m_lvl[i] = seen;
              m_run[i] = 0;
              ev[i]    = (seen == 1'b0);
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      if (rst_s) begin
        m_st = 0; m_a = 4'd0; m_b = 4'd0; m_cin = 1'b0; m_valid = 1'b0; m_err = 1'b0;
        m_live = 1'b1;
      end else if (ev[1]) begin
        m_st = 0; m_a = 4'd0; m_b = 4'd0; m_cin = 1'b0; m_valid = 1'b0; m_err = 1'b0;
      end else if (ev[0]) begin
        if (m_st == 0 || m_st == 1) begin
          if (HEX || dig <= 4'd9) begin
            if (m_st == 0) m_a = dig;
            else           m_b = dig;
            m_err = 1'b0;
            m_st  = m_st + 1;
          end else begin
            m_err = 1'b1;
          end
        end else if (m_st == 2) begin
          m_cin = cin_s; m_valid = 1'b1; m_st = 3;
        end else begin
          m_valid = 1'b0; m_st = 0;
        end
      end
      if (m_live) begin
        check("outputs_vs_model",
              {3'd0, a_out, b_out, cin_out, operands_valid, digit_err, entry_state},
              {3'd0, m_a, m_b, m_cin, m_valid, m_err, m_st[1:0]});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_enter(input logic [3:0] d, input logic c);
    digit_in    = d;
    cin_in      = c;
    key_enter_n = 1'b0;
    tick(DB + 2);
  endtask

  task automatic release_keys();
    tick(4);
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    tick(DB + 4);
  endtask

  initial begin
    reset       = 1'b1;
    digit_in    = 4'd0;
    cin_in      = 1'b0;
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;

    // 1. reset for two cycles
    tick(2);
    check("reset_a",     a_out, 16'd0);
    check("reset_b",     b_out, 16'd0);
    check("reset_cin",   cin_out, 16'd0);
    check("reset_valid", operands_valid, 16'd0);
    check("reset_err",   digit_err, 16'd0);
    check("reset_state", entry_state, 16'd0);
    reset = 1'b0;
    tick(2);

    // 2. full entry, with exact latency on the first press
    digit_in    = 4'd3;
    key_enter_n = 1'b0;
    tick(DB + 1);
    check("lat_before_state", entry_state, 16'd0);
    tick(1);
    check("lat_at_state", entry_state, 16'd1);
    check("a_is_3",       a_out, 16'd3);
    release_keys();
    press_enter(4'd5, 1'b0);
    check("b_is_5",     b_out, 16'd5);
    check("state_cin",  entry_state, 16'd2);
    release_keys();
    press_enter(4'd0, 1'b1);
    check("cin_is_1",   cin_out, 16'd1);
    check("valid_set",  operands_valid, 16'd1);
    check("state_done", entry_state, 16'd3);
    release_keys();
    press_enter(4'd0, 1'b0);
    check("done_valid_clr", operands_valid, 16'd0);
    check("done_to_a",      entry_state, 16'd0);
    check("done_a_holds",   a_out, 16'd3);
    release_keys();

    // 3. bounce of DB-1 cycles is ignored
    key_enter_n = 1'b0;
    tick(DB - 1);
    key_enter_n = 1'b1;
    tick(DB + 6);
    check("bounce_state", entry_state, 16'd0);
    check("bounce_a",     a_out, 16'd3);

    // 4. non-BCD digit rejected (accepted in hex build), then a legal digit
    press_enter(4'd12, 1'b0);
    check("d12_state", entry_state, HEX ? 16'd1 : 16'd0);
    check("d12_err",   digit_err,   HEX ? 16'd0 : 16'd1);
    check("d12_a",     a_out,       HEX ? 16'd12 : 16'd3);
    release_keys();
    press_enter(4'd7, 1'b0);
    check("d7_state", entry_state, HEX ? 16'd2 : 16'd1);
    check("d7_err",   digit_err, 16'd0);
    check("d7_a",     a_out, HEX ? 16'd12 : 16'd7);
    release_keys();

    // clear alone
    key_clear_n = 1'b0;
    tick(DB + 2);
    check("clr_state", entry_state, 16'd0);
    check("clr_a",     a_out, 16'd0);
    check("clr_b",     b_out, 16'd0);
    release_keys();

    // 5. clear and enter land together in S_B: clear wins
    press_enter(4'd2, 1'b0);
    check("sb_state", entry_state, 16'd1);
    release_keys();
    key_enter_n = 1'b0;
    key_clear_n = 1'b0;
    tick(DB + 2);
    check("both_state", entry_state, 16'd0);
    check("both_a",     a_out, 16'd0);
    check("both_valid", operands_valid, 16'd0);
    tick(20);
    check("both_held_state", entry_state, 16'd0);
    release_keys();

    // 6. reach S_DONE, then a one-cycle reset
    press_enter(4'd4, 1'b0);
    release_keys();
    press_enter(4'd6, 1'b0);
    release_keys();
    press_enter(4'd0, 1'b0);
    check("pre_rst_state", entry_state, 16'd3);
    check("pre_rst_b",     b_out, 16'd6);
    release_keys();
    reset = 1'b1;
    tick(1);
    check("rst_done_a",     a_out, 16'd0);
    check("rst_done_b",     b_out, 16'd0);
    check("rst_done_valid", operands_valid, 16'd0);
    check("rst_done_state", entry_state, 16'd0);
    reset = 1'b0;
    tick(2);

    // reset in the middle of a debounce abandons it
    digit_in    = 4'd8;
    key_enter_n = 1'b0;
    tick(DB - 1);
    reset       = 1'b1;
    key_enter_n = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(DB + 6);
    check("mid_rst_state", entry_state, 16'd0);
    check("mid_rst_a",     a_out, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
